// File: rtl/lsu_pfu_biu_pe_arb_pkg.sv
// ============================================================================
// Module  : lsu_pfu_biu_pe_arb_pkg
// Purpose : Shared constants for the prefetch-to-BIU arbiter: source
//           encodings, pending-bit indices and default sizes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pfu_biu_pe_arb_pkg;
  localparam int ENTRY_NUM_DEF = 8;
  localparam int PA_WIDTH_DEF  = 40;

  // Encoding of pfu_biu_pe_req_src
  localparam logic PFU_SRC_L1 = 1'b0;
  localparam logic PFU_SRC_L2 = 1'b1;

  // Bit positions inside a per-entry pending-source pair
  localparam int SRC_L1_BIT = 0;
  localparam int SRC_L2_BIT = 1;
  localparam int SRC_W      = 2;
endpackage

`default_nettype wire

// File: rtl/lsu_pfu_biu_pe_arb_if.sv
// ============================================================================
// Module  : lsu_pfu_biu_pe_arb_if
// Purpose : Bundle of prefetch-entry request signals and the BIU handshake.
//           master = entries/BIU side, slave = arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface lsu_pfu_biu_pe_arb_if
  import lsu_pfu_biu_pe_arb_pkg::*;
#(
  parameter int ENTRY_NUM = ENTRY_NUM_DEF,
  parameter int PA_WIDTH  = PA_WIDTH_DEF
);
  logic                            pfu_dcache_pref_en;
  logic [ENTRY_NUM-1:0]            entry_pop_vld;
  logic [ENTRY_NUM-1:0]            entry_l1_biu_pe_req_set;
  logic [ENTRY_NUM-1:0]            entry_l2_biu_pe_req_set;
  logic [ENTRY_NUM*PA_WIDTH-1:0]   entry_l1_pf_addr;
  logic [ENTRY_NUM*PA_WIDTH-1:0]   entry_l2_pf_addr;
  logic [ENTRY_NUM-1:0]            entry_l1_page_sec;
  logic [ENTRY_NUM-1:0]            entry_l1_page_share;
  logic [ENTRY_NUM-1:0]            entry_l2_page_sec;
  logic [ENTRY_NUM-1:0]            entry_l2_page_share;
  logic                            biu_pfu_pe_req_grnt;

  logic [ENTRY_NUM-1:0]            entry_biu_pe_req;
  logic [ENTRY_NUM*SRC_W-1:0]      entry_biu_pe_req_src;
  logic [ENTRY_NUM-1:0]            entry_biu_pe_req_grnt;
  logic                            pfu_biu_pe_req_sel_l1;
  logic                            pfu_biu_pe_req;
  logic [PA_WIDTH-1:0]             pfu_biu_pe_req_addr;
  logic                            pfu_biu_pe_req_page_sec;
  logic                            pfu_biu_pe_req_page_share;
  logic                            pfu_biu_pe_req_src;

  modport master (
    output pfu_dcache_pref_en, entry_pop_vld, entry_l1_biu_pe_req_set,
           entry_l2_biu_pe_req_set, entry_l1_pf_addr, entry_l2_pf_addr,
           entry_l1_page_sec, entry_l1_page_share, entry_l2_page_sec,
           entry_l2_page_share, biu_pfu_pe_req_grnt,
    input  entry_biu_pe_req, entry_biu_pe_req_src, entry_biu_pe_req_grnt,
           pfu_biu_pe_req_sel_l1, pfu_biu_pe_req, pfu_biu_pe_req_addr,
           pfu_biu_pe_req_page_sec, pfu_biu_pe_req_page_share,
           pfu_biu_pe_req_src
  );

  modport slave (
    input  pfu_dcache_pref_en, entry_pop_vld, entry_l1_biu_pe_req_set,
           entry_l2_biu_pe_req_set, entry_l1_pf_addr, entry_l2_pf_addr,
           entry_l1_page_sec, entry_l1_page_share, entry_l2_page_sec,
           entry_l2_page_share, biu_pfu_pe_req_grnt,
    output entry_biu_pe_req, entry_biu_pe_req_src, entry_biu_pe_req_grnt,
           pfu_biu_pe_req_sel_l1, pfu_biu_pe_req, pfu_biu_pe_req_addr,
           pfu_biu_pe_req_page_sec, pfu_biu_pe_req_page_share,
           pfu_biu_pe_req_src
  );
endinterface

`default_nettype wire

// File: rtl/lsu_pfu_biu_pe_arb_rr_sel.sv
// ============================================================================
// Module  : lsu_pfu_rr_sel
// Purpose : Round-robin find-first-set. Scans the request vector upward
//           starting at the pointer, wrapping from N-1 back to 0.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_pfu_rr_sel
  import lsu_pfu_biu_pe_arb_pkg::*;
#(
  parameter int N = ENTRY_NUM_DEF,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic          o_found
);
  localparam logic [PW:0] C_N = (PW+1)'(N);

  // Walk N positions from the pointer; the first requester seen wins
  always_comb begin
    logic [PW:0]   v_sum;
    logic [PW-1:0] v_idx;
    o_grant = '0;
    o_found = 1'b0;
    v_sum   = '0;
    v_idx   = '0;
    for (int k = 0; k < N; k++) begin
      v_sum = {1'b0, i_ptr} + (PW+1)'(k);
      if (v_sum >= C_N) v_sum = v_sum - C_N;
      v_idx = v_sum[PW-1:0];
      if (!o_found && i_req[v_idx]) begin
        o_grant[v_idx] = 1'b1;
        o_found        = 1'b1;
      end
    end
  end
endmodule

`default_nettype wire

// File: rtl/lsu_pfu_biu_pe_arb.sv
// ============================================================================
// Module  : lsu_pfu_biu_pe_arb
// Purpose : Latches per-entry L1/L2 prefetch requests, picks one entry per
//           cycle round-robin (L1 before L2 inside an entry) and drives a
//           single registered request toward the BIU.
// Options : PFU_BIU_ARB_L2_EN - when defined, the L2 source is arbitrated;
//           otherwise L2 inputs are ignored and only L1 is served.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_pfu_biu_pe_arb
  import lsu_pfu_biu_pe_arb_pkg::*;
#(
  parameter int ENTRY_NUM = ENTRY_NUM_DEF,
  parameter int PA_WIDTH  = PA_WIDTH_DEF
) (
  input  logic                 forever_cpuclk,
  input  logic                 cpurst_b,
  lsu_pfu_biu_pe_arb_if.slave  bus
);
  localparam int PW = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;

  logic [ENTRY_NUM-1:0]       r_src_l1;
  logic [ENTRY_NUM-1:0]       w_src_l2;
  logic [ENTRY_NUM-1:0]       w_req;
  logic [ENTRY_NUM-1:0]       w_sel_oh;
  logic [ENTRY_NUM-1:0]       w_grnt_oh;
  logic [ENTRY_NUM*SRC_W-1:0] w_src_flat;
  logic                       w_found;
  logic                       w_slot_free;
  logic                       w_grant;
  logic                       w_win_l1;
  logic                       w_win_pop;
  logic [PW-1:0]              r_rr_ptr;
  logic [PW-1:0]              w_win;
  logic [PW-1:0]              w_ptr_nxt;
  logic [PA_WIDTH-1:0]        w_l1_addr [ENTRY_NUM];
  logic [PA_WIDTH-1:0]        w_sel_addr;
  logic                       w_sel_sec;
  logic                       w_sel_share;
  logic                       w_sel_src;
  logic                       r_req_vld;
  logic [PA_WIDTH-1:0]        r_req_addr;
  logic                       r_req_sec;
  logic                       r_req_share;
  logic                       r_req_src;

  for (genvar gi = 0; gi < ENTRY_NUM; gi++) begin : g_unpack_l1
    assign w_l1_addr[gi] = bus.entry_l1_pf_addr[gi*PA_WIDTH +: PA_WIDTH];
  end

  assign w_req = r_src_l1 | w_src_l2;

  lsu_pfu_rr_sel #(.N(ENTRY_NUM)) u_rr_sel (
    .i_req   (w_req),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_sel_oh),
    .o_found (w_found)
  );

  // Convert the one-hot winner into an index
  always_comb begin
    w_win = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (w_sel_oh[i]) w_win = PW'(i);
    end
  end

  // A popping winner forfeits the cycle rather than passing to the next entry
  assign w_win_pop   = |(w_sel_oh & bus.entry_pop_vld);
  assign w_slot_free = !r_req_vld || bus.biu_pfu_pe_req_grnt;
  assign w_grant     = cpurst_b && bus.pfu_dcache_pref_en && w_slot_free &&
                       w_found && !w_win_pop;
  assign w_win_l1    = r_src_l1[w_win];
  assign w_grnt_oh   = w_grant ? w_sel_oh : '0;
  assign w_ptr_nxt   = (w_win == PW'(ENTRY_NUM-1)) ? '0 : w_win + PW'(1);

  // L1 pending bits: flush, pop, set, then grant-clear in priority order
  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b || !bus.pfu_dcache_pref_en) begin
      r_src_l1 <= '0;
    end else begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        if (bus.entry_pop_vld[i])                r_src_l1[i] <= 1'b0;
        else if (bus.entry_l1_biu_pe_req_set[i]) r_src_l1[i] <= 1'b1;
        else if (w_grnt_oh[i] && w_win_l1)       r_src_l1[i] <= 1'b0;
      end
    end
  end

`ifdef PFU_BIU_ARB_L2_EN
  logic [ENTRY_NUM-1:0] r_src_l2;
  logic [PA_WIDTH-1:0]  w_l2_addr [ENTRY_NUM];

  for (genvar gj = 0; gj < ENTRY_NUM; gj++) begin : g_unpack_l2
    assign w_l2_addr[gj] = bus.entry_l2_pf_addr[gj*PA_WIDTH +: PA_WIDTH];
  end

  // L2 pending bits: same priority as L1, cleared only by an L2 grant
  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b || !bus.pfu_dcache_pref_en) begin
      r_src_l2 <= '0;
    end else begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        if (bus.entry_pop_vld[i])                r_src_l2[i] <= 1'b0;
        else if (bus.entry_l2_biu_pe_req_set[i]) r_src_l2[i] <= 1'b1;
        else if (w_grnt_oh[i] && !w_win_l1)      r_src_l2[i] <= 1'b0;
      end
    end
  end

  assign w_src_l2 = r_src_l2;

  // L1 wins inside an entry; L2 is used only when L1 is idle
  always_comb begin
    w_sel_addr  = w_win_l1 ? w_l1_addr[w_win] : w_l2_addr[w_win];
    w_sel_sec   = w_win_l1 ? bus.entry_l1_page_sec[w_win]
                           : bus.entry_l2_page_sec[w_win];
    w_sel_share = w_win_l1 ? bus.entry_l1_page_share[w_win]
                           : bus.entry_l2_page_share[w_win];
    w_sel_src   = w_win_l1 ? PFU_SRC_L1 : PFU_SRC_L2;
  end

  assign bus.pfu_biu_pe_req_sel_l1 = w_grant && w_win_l1;
`else
  logic w_unused_l2;

  assign w_src_l2    = '0;
  assign w_unused_l2 = ^{bus.entry_l2_biu_pe_req_set, bus.entry_l2_pf_addr,
                         bus.entry_l2_page_sec, bus.entry_l2_page_share};

  // Only the L1 source exists in this build
  always_comb begin
    w_sel_addr  = w_l1_addr[w_win];
    w_sel_sec   = bus.entry_l1_page_sec[w_win];
    w_sel_share = bus.entry_l1_page_share[w_win];
    w_sel_src   = PFU_SRC_L1;
  end

  assign bus.pfu_biu_pe_req_sel_l1 = |w_grnt_oh;
`endif

  // Output slot: load on a grant, otherwise drop once the BIU accepts
  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      r_req_vld   <= 1'b0;
      r_req_addr  <= '0;
      r_req_sec   <= 1'b0;
      r_req_share <= 1'b0;
      r_req_src   <= 1'b0;
      r_rr_ptr    <= '0;
    end else if (w_grant) begin
      r_req_vld   <= 1'b1;
      r_req_addr  <= w_sel_addr;
      r_req_sec   <= w_sel_sec;
      r_req_share <= w_sel_share;
      r_req_src   <= w_sel_src;
      r_rr_ptr    <= w_ptr_nxt;
    end else if (bus.biu_pfu_pe_req_grnt) begin
      r_req_vld   <= 1'b0;
    end
  end

  // Pack the per-entry pending pairs as {L2, L1}
  always_comb begin
    w_src_flat = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      w_src_flat[SRC_W*i + SRC_L1_BIT] = r_src_l1[i];
      w_src_flat[SRC_W*i + SRC_L2_BIT] = w_src_l2[i];
    end
  end

  assign bus.entry_biu_pe_req          = w_req;
  assign bus.entry_biu_pe_req_src      = w_src_flat;
  assign bus.entry_biu_pe_req_grnt     = w_grnt_oh;
  assign bus.pfu_biu_pe_req            = r_req_vld;
  assign bus.pfu_biu_pe_req_addr       = r_req_addr;
  assign bus.pfu_biu_pe_req_page_sec   = r_req_sec;
  assign bus.pfu_biu_pe_req_page_share = r_req_share;
  assign bus.pfu_biu_pe_req_src        = r_req_src;
endmodule

`default_nettype wire
